display_scan: RTL

Eight-digit multiplexed seven-segment driver that consumes the 32-bit `display` word produced by the pipeline top (the SYSCALL result register) and drives board anodes and segments. It samples `display` into a snapshot register only at frame boundaries so that a digit never changes mid-frame. It scans the eight hex digits at a programmable rate. Instantiated beside the pipeline top on the board wrapper; it has no feedback into the CPU.

---
 rtl/display_scan.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/display_scan.sv
// display_scan -- eight-digit multiplexed seven-segment driver.
//
// Scans the eight hex digits of a 32-bit snapshot of `display`, one digit
// every SCAN_DIV clock cycles. The snapshot is reloaded only at the frame
// wrap (digit 7 -> digit 0), so a digit never changes in the middle of a
// frame. All outputs (an, seg, frame) are registered and lag the scan state
// by one cycle.
//
// Optional feature: define DISPLAY_SCAN_LZB_EN to enable leading-zero
// blanking. Digit k > 0 is blanked when every snapshot nibble from k upward
// is zero. Digit 0 is never blanked. Without the macro, all eight digits are
// always decoded and no blanking logic exists.

module display_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        CLR,
  input  logic [31:0] display,
  input  logic        hold,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame
);

  // The prescaler needs at least one bit, even when SCAN_DIV == 1.
  localparam int              PW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   P_LAST = PW'(SCAN_DIV - 1);

  // Scan state
  logic [PW-1:0] r_pcnt;
  logic [2:0]    r_idx;
  logic [31:0]   r_snap;
  logic          r_wrap;

  // Registered outputs
  logic [7:0]    r_an;
  logic [7:0]    r_seg;
  logic          r_frame;

  // Decode path
  logic          w_tick;
  logic          w_wrap;
  logic [4:0]    w_bit_base;
  logic [3:0]    w_nibble;
  logic [7:0]    w_seg_dec;
  logic [7:0]    w_seg_next;

  // Active-low hex decode, {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // The tick ends each digit slot; the wrap tick ends the frame.
  assign w_tick     = (r_pcnt == P_LAST);
  assign w_wrap     = w_tick && (r_idx == 3'd7);

  // Select the nibble for the current digit from the current snapshot.
  assign w_bit_base = {r_idx, 2'b00};
  assign w_nibble   = r_snap[w_bit_base +: 4];
  assign w_seg_dec  = hex_to_seg(w_nibble);

`ifdef DISPLAY_SCAN_LZB_EN
  logic w_blank;

  // Blank a leading zero: this digit and every digit above it are zero.
  // Digit 0 always shows, so a zero word still displays a single "0".
  assign w_blank = (r_idx != 3'd0) && ((r_snap >> w_bit_base) == 32'd0);

  // Segment value for the next output register update, with blanking.
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    w_seg_next = w_seg_dec;
    if (w_blank) begin
      w_seg_next = 8'hFF;
    end
  end
`else
  // Segment value for the next output register update, no blanking.
  always_comb begin
    w_seg_next = w_seg_dec;
  end
`endif

  // Prescaler: counts 0..SCAN_DIV-1 and wraps on the tick.
  always_ff @(posedge clk or negedge CLR) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (!CLR) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  // Digit index: advances once per tick, wrapping 7 -> 0 naturally.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      r_idx <= 3'd0;
    end else if (w_tick) begin
      r_idx <= r_idx + 3'd1;
    end
  end

  // Snapshot: reloaded only on the wrap tick, and only when hold is low.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      r_snap <= 32'd0;
    end else if (w_wrap && !hold) begin
      r_snap <= display;
    end
  end

  // Frame marker: delayed one extra cycle so the pulse lines up with the
  // output register showing digit 0 of the new snapshot.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      r_wrap  <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_wrap  <= w_wrap;
      r_frame <= r_wrap;
    end
  end

  // Output register: anode and segments from the current index and snapshot.
  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      r_an  <= 8'hFF;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= ~(8'b1 << r_idx);
      r_seg <= w_seg_next;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign frame = r_frame;

endmodule
